// File: rtl/array_shift_engine.sv
// Multi-cycle array engine: READ/WRITE/RESIZE/SIZE plus shift-up/shift-down at any index, one element moved per cycle.
// Latency m+1 cycles; starts are ignored while busy. Define ARRAY_SHIFT_FULL_CHECK_EN to reject SHIFT_UP on a full array.
module array_shift_engine #(
   parameter int MemoryElementWidth = 12,
   parameter int NArea              = 10,
   parameter int NArrays            = 20,
   parameter int AW                 = $clog2(NArrays),
   parameter int IW                 = $clog2(NArea + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [2:0]                    op,
   input  logic [AW-1:0]                 array,
   input  logic [IW-1:0]                 index,
   input  logic [MemoryElementWidth-1:0] data_in,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [MemoryElementWidth-1:0] data_out,
   output logic [IW-1:0]                 size_out
);
   localparam int W  = MemoryElementWidth;
   localparam int XW = IW + 1;
   localparam int HN = NArrays * NArea;
   localparam int HW = $clog2(HN);
   localparam logic [XW-1:0] AREA = XW'(NArea);

   localparam logic [2:0] OP_READ   = 3'd0;
   localparam logic [2:0] OP_WRITE  = 3'd1;
   localparam logic [2:0] OP_RESIZE = 3'd2;
   localparam logic [2:0] OP_UP     = 3'd3;
   localparam logic [2:0] OP_DOWN   = 3'd4;
   localparam logic [2:0] OP_SIZE   = 3'd5;

   typedef enum logic [1:0] {IDLE, MOVE, FINISH} state_t;
   state_t state, state_nxt;

   logic [W-1:0]  heap  [HN];
   logic [IW-1:0] sizes [NArrays];

   logic [2:0]    op_q;
   logic [AW-1:0] arr_q;
   logic [XW-1:0] idx_q, ptr_q, cnt_q, size_q;
   logic [W-1:0]  din_q, rm_q;
   logic          err_q;

   logic          arr_ok, req_err;
   logic [XW-1:0] cur_size, idx_x, top, m, new_size;
   logic [HW-1:0] in_addr, base_q, mv_dst, mv_src, fin_addr, hw_addr;
   logic [W-1:0]  hw_dat;
   logic          hw_en;

   // Request decode, evaluated against the live inputs while idle.
   always_comb begin
      arr_ok   = int'(array) < NArrays;
      cur_size = arr_ok ? XW'(sizes[array]) : '0;
      idx_x    = XW'(index);
      top      = (cur_size < AREA) ? cur_size : AREA - XW'(1);
      in_addr  = (arr_ok && idx_x < AREA) ? HW'(array) * HW'(NArea) + HW'(index) : '0;
      req_err  = 1'b0;
      m        = '0;
      case (op)
         OP_READ:   req_err = idx_x >= cur_size;
         OP_WRITE:  req_err = idx_x >= AREA;
         OP_RESIZE: req_err = idx_x > AREA;
         OP_SIZE:   req_err = 1'b0;
`ifdef ARRAY_SHIFT_FULL_CHECK_EN
         OP_UP:     req_err = (idx_x > cur_size) || (cur_size == AREA);
`else
         OP_UP:     req_err = idx_x > cur_size;
`endif
         OP_DOWN:   req_err = idx_x >= cur_size;
         default:   req_err = 1'b1;
      endcase
      if (!arr_ok)
         req_err = 1'b1;
      if (!req_err) begin
         // Inserting at index NArea of a full array has nothing to move.
         if (op == OP_UP && top > idx_x)
            m = top - idx_x;
         else if (op == OP_DOWN)
            m = cur_size - XW'(1) - idx_x;
      end
   end

   always_comb begin
      base_q   = HW'(arr_q) * HW'(NArea);
      mv_dst   = base_q + HW'(ptr_q);
      mv_src   = (op_q == OP_UP) ? mv_dst - HW'(1) : mv_dst + HW'(1);
      fin_addr = base_q + HW'(idx_q);
      case (op_q)
         OP_RESIZE: new_size = idx_q;
         OP_UP:     new_size = (size_q < AREA) ? size_q + XW'(1) : AREA;
         OP_DOWN:   new_size = size_q - XW'(1);
         default:   new_size = size_q;
      endcase
      if (err_q)
         new_size = size_q;
   end

   always_comb begin
      state_nxt = state;
      hw_en     = 1'b0;
      hw_addr   = mv_dst;
      hw_dat    = heap[mv_src];
      case (state)
         IDLE:
            if (start)
               state_nxt = (m != '0) ? MOVE : FINISH;
         MOVE: begin
            hw_en = 1'b1;
            if (cnt_q == XW'(1))
               state_nxt = FINISH;
         end
         FINISH: begin
            state_nxt = IDLE;
            hw_addr   = fin_addr;
            hw_dat    = din_q;
            hw_en     = !err_q && (op_q == OP_WRITE || (op_q == OP_UP && idx_q < AREA));
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (hw_en)
         heap[hw_addr] <= hw_dat;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         data_out <= '0;
         size_out <= '0;
         op_q     <= '0;
         arr_q    <= '0;
         idx_q    <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         size_q   <= '0;
         din_q    <= '0;
         rm_q     <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < NArrays; i++)
            sizes[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  busy   <= 1'b1;
                  op_q   <= op;
                  arr_q  <= array;
                  idx_q  <= idx_x;
                  din_q  <= data_in;
                  err_q  <= req_err;
                  size_q <= cur_size;
                  rm_q   <= heap[in_addr];
                  cnt_q  <= m;
                  ptr_q  <= (op == OP_UP) ? top : idx_x;
               end
            MOVE: begin
               cnt_q <= cnt_q - XW'(1);
               ptr_q <= (op_q == OP_UP) ? ptr_q - XW'(1) : ptr_q + XW'(1);
            end
            FINISH: begin
               busy     <= 1'b0;
               done     <= 1'b1;
               error    <= err_q;
               size_out <= IW'(new_size);
               if (!err_q) begin
                  sizes[arr_q] <= IW'(new_size);
                  if (op_q == OP_READ)
                     data_out <= heap[fin_addr];
                  else if (op_q == OP_DOWN)
                     data_out <= rm_q;
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_array_shift_engine.sv
// Bench for array_shift_engine: table of operations checked through a scoreboard of expected completions.
module tb_array_shift_engine;
   localparam int W  = 12;
   localparam int AW = 5;
   localparam int IW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = '0;
   logic [AW-1:0] array = '0;
   logic [IW-1:0] index = '0;
   logic [W-1:0]  data_in = '0;
   logic          busy, done, error;
   logic [W-1:0]  data_out;
   logic [IW-1:0] size_out;

   array_shift_engine dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .array(array), .index(index),
      .data_in(data_in), .busy(busy), .done(done), .error(error), .data_out(data_out),
      .size_out(size_out)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] op;
      int arr, idx, din;
      bit err, chk;
      int dat, sz, lat;
   } vec_t;

   typedef struct {
      bit err, chk;
      int dat, sz, lat, acc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic void add(input logic [2:0] o, input int a, input int ix, input int d,
                               input bit e, input bit c, input int dt, input int sz, input int lt);
      vec_t v;
      v.op = o; v.arr = a; v.idx = ix; v.din = d;
      v.err = e; v.chk = c; v.dat = dt; v.sz = sz; v.lat = lt;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int tag, input int act, input int expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s tag=%0d got=%0d expected=%0d", nm, tag, act, expv);
      end
   endtask

   task automatic issue(input logic [2:0] o, input int a, input int ix, input int d,
                        input bit e, input bit c, input int dt, input int sz, input int lt,
                        input bit hold);
      exp_t x;
      int   k;
      k = 0;
      @(negedge clock);
      while (busy && k < 60) begin
         @(negedge clock);
         k++;
      end
      op      = o;
      array   = a[AW-1:0];
      index   = ix[IW-1:0];
      data_in = d[W-1:0];
      start   = 1'b1;
      @(posedge clock);
      #1;
      x.err = e; x.chk = c; x.dat = dt; x.sz = sz; x.lat = lt; x.acc = cyc;
      sb.push_back(x);
      if (!hold)
         start = 1'b0;
   endtask

   task automatic wait_done(input int tag);
      exp_t x;
      int   k;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!done && k < 60);
      n_chk++;
      if (!done || sb.size() == 0) begin
         n_fail++;
         $display("FAIL done_seen tag=%0d got done=%0d expected done=1 pending=%0d", tag, done, sb.size());
         sb.delete();
      end else begin
         x = sb.pop_front();
         chk("error", tag, int'(error), int'(x.err));
         chk("size_out", tag, int'(size_out), x.sz);
         chk("latency", tag, cyc - x.acc, x.lat);
         if (x.chk)
            chk("data_out", tag, int'(data_out), x.dat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=running expected=finished");
      $fatal(1);
   end

   initial begin
      // op codes: 0 READ, 1 WRITE, 2 RESIZE, 3 SHIFT_UP, 4 SHIFT_DOWN, 5 SIZE
      for (int k = 0; k < 3; k++) add(3'd1, 1, k, k, 0, 0, 0, 0, 1);
      add(3'd2, 1, 3, 0, 0, 0, 0, 3, 1);
      add(3'd3, 1, 0, 99, 0, 0, 0, 4, 4);
      add(3'd0, 1, 0, 0, 0, 1, 99, 4, 1);
      add(3'd0, 1, 1, 0, 0, 1, 0, 4, 1);
      add(3'd0, 1, 2, 0, 0, 1, 1, 4, 1);
      add(3'd0, 1, 3, 0, 0, 1, 2, 4, 1);
      add(3'd3, 1, 4, 55, 0, 0, 0, 5, 1);
      add(3'd0, 1, 4, 0, 0, 1, 55, 5, 1);
      add(3'd4, 1, 4, 0, 0, 1, 55, 4, 1);
      for (int k = 0; k < 4; k++) add(3'd1, 2, k, k + 5, 0, 0, 0, 0, 1);
      add(3'd2, 2, 4, 0, 0, 0, 0, 4, 1);
      add(3'd4, 2, 1, 0, 0, 1, 6, 3, 3);
      add(3'd0, 2, 0, 0, 0, 1, 5, 3, 1);
      add(3'd0, 2, 1, 0, 0, 1, 7, 3, 1);
      add(3'd0, 2, 2, 0, 0, 1, 8, 3, 1);
      add(3'd0, 2, 3, 0, 1, 0, 0, 3, 1);
      add(3'd4, 5, 0, 0, 1, 0, 0, 0, 1);
      add(3'd2, 2, 11, 0, 1, 0, 0, 3, 1);
      add(3'd7, 2, 0, 0, 1, 0, 0, 3, 1);
      add(3'd0, 20, 0, 0, 1, 0, 0, 0, 1);
      add(3'd1, 2, 10, 33, 1, 0, 0, 3, 1);
      add(3'd3, 2, 4, 33, 1, 0, 0, 3, 1);
      add(3'd5, 2, 0, 0, 0, 0, 0, 3, 1);
      add(3'd0, 2, 2, 0, 0, 1, 8, 3, 1);
      for (int k = 0; k < 10; k++) add(3'd1, 0, k, k, 0, 0, 0, 0, 1);
      add(3'd2, 0, 10, 0, 0, 0, 0, 10, 1);
`ifdef ARRAY_SHIFT_FULL_CHECK_EN
      add(3'd3, 0, 0, 42, 1, 0, 0, 10, 1);
      for (int k = 0; k < 10; k++) add(3'd0, 0, k, 0, 0, 1, k, 10, 1);
`else
      add(3'd3, 0, 0, 42, 0, 0, 0, 10, 10);
      add(3'd0, 0, 0, 0, 0, 1, 42, 10, 1);
      for (int k = 1; k < 10; k++) add(3'd0, 0, k, 0, 0, 1, k - 1, 10, 1);
`endif

      repeat (2) @(negedge clock);
      chk("reset_busy", -1, int'(busy), 0);
      chk("reset_done", -1, int'(done), 0);
      chk("reset_error", -1, int'(error), 0);
      chk("reset_data_out", -1, int'(data_out), 0);
      chk("reset_size_out", -1, int'(size_out), 0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].op, vecs[i].arr, vecs[i].idx, vecs[i].din, vecs[i].err, vecs[i].chk,
               vecs[i].dat, vecs[i].sz, vecs[i].lat, 1'b0);
         wait_done(i);
      end

      // Array 3 = [0..4]; SHIFT_UP with start held high must execute once.
      for (int k = 0; k < 5; k++) begin
         issue(3'd1, 3, k, k, 0, 0, 0, 0, 1, 1'b0);
         wait_done(100 + k);
      end
      issue(3'd2, 3, 5, 0, 0, 0, 0, 5, 1, 1'b0);
      wait_done(105);
      issue(3'd3, 3, 0, 77, 0, 0, 0, 6, 6, 1'b1);
      repeat (2) @(negedge clock);
      chk("busy_held", 106, int'(busy), 1);
      wait_done(107);
      op    = 3'd5;
      array = 5'd3;
      @(posedge clock);
      #1;
      begin
         exp_t x;
         x.err = 0; x.chk = 0; x.dat = 0; x.sz = 6; x.lat = 1; x.acc = cyc;
         sb.push_back(x);
      end
      start = 1'b0;
      wait_done(108);
      issue(3'd0, 3, 0, 0, 0, 1, 77, 6, 1, 1'b0);
      wait_done(109);
      issue(3'd0, 3, 5, 0, 0, 1, 4, 6, 1, 1'b0);
      wait_done(110);

      // Reset during MOVE of a SHIFT_UP aborts the operation.
      issue(3'd3, 3, 0, 11, 0, 0, 0, 7, 7, 1'b0);
      repeat (2) @(negedge clock);
      chk("busy_in_move", 111, int'(busy), 1);
      reset = 1'b0;
      #1;
      chk("abort_busy", 112, int'(busy), 0);
      chk("abort_done", 112, int'(done), 0);
      chk("abort_error", 112, int'(error), 0);
      chk("abort_size_out", 112, int'(size_out), 0);
      sb.delete();
      @(negedge clock);
      reset = 1'b1;
      issue(3'd5, 3, 0, 0, 0, 0, 0, 0, 1, 1'b0);
      wait_done(113);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/array_shift_engine.md
# array_shift_engine

Parametrised, multi-cycle array-manipulation engine holding NArrays fixed-size areas of NArea elements plus a size per array. It executes read, write, resize, size, shift-up (insert at any index) and shift-down (remove at any index) on request. It replaces the single-cycle, insert-at-zero-only shift done inline by the instruction interpreter. It sits beside the interpreter's local memory, and the interpreter issues one operation at a time over a start/done handshake.

## Interface
Parameters:
- MemoryElementWidth, 12, width of every stored element and of data ports
- NArea, 10, elements per array area (≥2)
- NArrays, 20, number of array areas
- AW, $clog2(NArrays), array-number width (derived)
- IW, $clog2(NArea+1), index/size width (derived)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all control state and array sizes
- start  in  1  request strobe, sampled only when busy=0
- op  in  3  0 READ, 1 WRITE, 2 RESIZE, 3 SHIFT_UP, 4 SHIFT_DOWN, 5 SIZE; 6–7 illegal
- array  in  AW  target array number
- index  in  IW  element index, or new size for RESIZE
- data_in  in  MemoryElementWidth  value for WRITE / SHIFT_UP
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; operation rejected, no state changed
- data_out  out  MemoryElementWidth  READ result, or removed element for SHIFT_DOWN; held until next done
- size_out  out  IW  size of target array after the operation; held until next done

## Operation
- Storage: heap[array*NArea + k]; sizes[array]. Heap contents are not reset; sizes reset to 0.
- States: IDLE, MOVE, FINISH.
- IDLE: on start, latch op/array/index/data_in, assert busy, go to MOVE if move count m>0, else to FINISH.
- READ: data_out=heap[index]; error if index ≥ size.
- WRITE: heap[index]=data_in; error if index ≥ NArea. Size is unchanged.
- RESIZE: size=index; error if index > NArea.
- SIZE: size_out only.
- SHIFT_UP: with top = min(size, NArea-1), move heap[j]=heap[j-1] for j=top down to index+1, one element per MOVE cycle, so m = top-index. In FINISH, heap[index]=data_in and size=min(size+1, NArea). Error if index > size.
- SHIFT_DOWN: data_out=heap[index] is captured at start. Move heap[j]=heap[j+1] for j=index up to size-2, so m = size-1-index. In FINISH, size=size-1. Error if size=0 or index ≥ size.
- Illegal op or array ≥ NArrays: error, no change.
- Errors are detected in IDLE and go straight to FINISH with m=0.
- FINISH: perform the final write, pulse done, drop busy, return to IDLE.

## Timing
- Reset values: busy=0, done=0, error=0, data_out=0, size_out=0, state=IDLE, all sizes=0.
- start accepted at edge t; busy=1 from t; done=1 and busy=0 after edge t+1+m. Latency is m+1 cycles.
- Simple ops and all errors have m=0, so done follows 1 cycle after accept.
- start while busy=1 is ignored: no error, no queueing.
- start may be re-asserted in the same cycle done is high; it is accepted because busy=0.
- Reset asserted mid-operation aborts at once. Sizes return to 0; partially shifted heap data is left as is.
- Index/size arithmetic is done in IW+1 bits; no wrap-around.

## Configuration
- ARRAY_SHIFT_FULL_CHECK_EN defined: SHIFT_UP on a full array (size=NArea) is rejected with error=1 and no change.
- Undefined: SHIFT_UP on a full array drops the last element (heap[NArea-1] is lost), inserts data_in, and leaves size saturated at NArea with error=0.

## Test plan
- WRITE 0,1,2 to array 1 at indices 0..2, RESIZE 3, SHIFT_UP index 0 value 99, READ 0..3 -> 99,0,1,2; size_out=4; SHIFT_UP done 4 cycles after accept (m=3).
- Array 2 holding [5,6,7,8], SHIFT_DOWN index 1 -> data_out=6, size_out=3, contents [5,7,8], done 3 cycles after accept (m=2).
- Fill array 0 to NArea=10 with values 0..9, SHIFT_UP index 0 value 42 -> macro defined: error=1, contents unchanged; macro undefined: contents [42,0..8], size_out=10.
- Boundary errors, each with error=1, done 1 cycle after accept, and no state change: READ index=size; SHIFT_DOWN on size 0; RESIZE 11; op=7; array=20.
- Hold start high while busy during a long SHIFT_UP -> only one operation executes; a new start in the done cycle is accepted.
- Pull reset low during the MOVE state of a SHIFT_UP -> busy, done and error go to 0 immediately; SIZE on that array afterwards returns 0.
